ma_injector_packetizer: RTL

//  Downstream stage of the MA stream source: consumes the raw MA boot stream and wraps each frame into a NoC packet

---
 rtl/ma_injector_packetizer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ma_injector_packetizer.sv
// MA boot stream packetizer: wraps every frame of the raw MA stream (mapper image,
// descriptor, remaining task images) into a NoC packet addressed to the mapper PE.
module ma_injector_packetizer #(
   parameter int unsigned          FLIT_SIZE = 32,
   parameter logic [FLIT_SIZE-1:0] SRV_TASK  = 'h40,
   parameter logic [FLIT_SIZE-1:0] SRV_DESCR = 'h41
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   output logic                 credit_o,
   input  logic [FLIT_SIZE-1:0] data_i,
   input  logic [15:0]          mapper_address_i,
   output logic                 tx_o,
   input  logic                 credit_i,
   output logic [FLIT_SIZE-1:0] data_o,
   output logic                 done_o
);

   typedef enum logic [3:0] {
      S_TXT,
      S_DAT,
      S_DCNT,
      S_HDR,
      S_SIZE,
      S_SRV,
      S_W0,
      S_W1,
      S_BODY,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [31:0]          frame_q;
   logic [31:0]          text_q;
   logic [31:0]          dsize_q;
   logic [31:0]          words_q;
   logic [31:0]          cnt_q;
   logic [31:0]          rem_q;
   logic                 tx_q;
   logic                 done_q;
   logic [FLIT_SIZE-1:0] data_q;

   logic                 load;
   logic                 is_descr;
   logic                 body_skip_d;
   logic [31:0]          in_word;
   logic [31:0]          pkt_size_d;
   logic [31:0]          body_len_d;
   logic [31:0]          words_d;
   logic [FLIT_SIZE-1:0] emit_d;
   state_t               after_body_d;

   assign in_word  = data_i[31:0];
   assign load     = !tx_q || credit_i;
   assign is_descr = (frame_q == 32'd1);

   assign tx_o   = tx_q;
   assign data_o = data_q;
   assign done_o = done_q;

   always_comb begin
      pkt_size_d  = is_descr ? (32'd3 + 32'd3 * cnt_q) : (32'd5 + words_q);
      body_len_d  = is_descr ? (32'd1 + 32'd3 * cnt_q) : (32'd2 + words_q);
      body_skip_d = (body_len_d == '0);
      words_d     = (text_q + in_word) >> 2;
   end

   // Frame sequencing: a cnt of 0 ends the stream after the descriptor, just like cnt==1.
   always_comb begin
      after_body_d = S_DONE;
      if (frame_q == '0) begin
         after_body_d = S_DCNT;
      end else if (is_descr) begin
         after_body_d = (cnt_q > 32'd1) ? S_TXT : S_DONE;
      end else begin
         after_body_d = (frame_q < cnt_q) ? S_TXT : S_DONE;
      end
   end

   always_comb begin
      emit_d = '0;
      case (state_q)
         S_HDR:   emit_d[15:0] = mapper_address_i;
         S_SIZE:  emit_d[31:0] = pkt_size_d;
         S_SRV:   emit_d       = is_descr ? SRV_DESCR : SRV_TASK;
         S_W0:    emit_d[31:0] = is_descr ? cnt_q : text_q;
         S_W1:    emit_d[31:0] = dsize_q;
         default: emit_d       = '0;
      endcase
   end

   always_comb begin
      case (state_q)
         S_TXT, S_DAT, S_DCNT: credit_o = 1'b1;
         S_BODY:               credit_o = load;
         default:              credit_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_TXT;
         frame_q <= '0;
         text_q  <= '0;
         dsize_q <= '0;
         words_q <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         tx_q    <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state_q)
            S_TXT, S_DAT, S_DCNT: begin
               if (load) begin
                  tx_q <= 1'b0;
               end
               if (rx_i) begin
                  case (state_q)
                     S_TXT: begin
                        text_q  <= in_word;
                        state_q <= S_DAT;
                     end
                     S_DAT: begin
                        dsize_q <= in_word;
                        words_q <= words_d;
                        state_q <= S_HDR;
                     end
                     default: begin
                        cnt_q   <= in_word;
                        state_q <= S_HDR;
                     end
                  endcase
               end
            end
            S_HDR, S_SIZE, S_SRV, S_W0, S_W1: begin
               if (load) begin
                  data_q <= emit_d;
                  tx_q   <= 1'b1;
                  rem_q  <= body_len_d;
                  case (state_q)
                     S_HDR:  state_q <= S_SIZE;
                     S_SIZE: state_q <= S_SRV;
                     S_SRV:  state_q <= S_W0;
                     default: begin
                        if (state_q == S_W0 && !is_descr) begin
                           state_q <= S_W1;
                        end else if (body_skip_d) begin
                           // A zero body length wraps straight to the next frame.
                           state_q <= after_body_d;
                           frame_q <= frame_q + 32'd1;
                        end else begin
                           state_q <= S_BODY;
                        end
                     end
                  endcase
               end
            end
            S_BODY: begin
               if (load) begin
                  if (rx_i) begin
                     data_q <= data_i;
                     tx_q   <= 1'b1;
                     rem_q  <= rem_q - 32'd1;
                     if (rem_q == 32'd1) begin
                        state_q <= after_body_d;
                        frame_q <= frame_q + 32'd1;
                     end
                  end else begin
                     tx_q <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (load) begin
                  tx_q   <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: state_q <= S_TXT;
         endcase
      end
   end

endmodule
